// File: rtl/pipe_handshake_source.sv
// pipe_handshake_source
//   Upstream end of a valid/ready/data pipe. Words pushed on the local port
//   are queued in a DEPTH-word FIFO and presented downstream in order through
//   a registered output, one word per cycle. Completed downstream transfers
//   are counted.
//
// Ports
//   clock          rising-edge clock
//   reset          asynchronous, active-low reset
//   flush          synchronous clear of all stored words (counter kept)
//   in_valid       local push request
//   in_data        local push payload
//   in_ready       push accepted this cycle (level != DEPTH, 0 in reset)
//   out_valid      downstream valid
//   out_data       downstream payload (registered)
//   out_ready      downstream accepts
//   level          words currently held, 0..DEPTH
//   transfer_count completed downstream handshakes, wraps
module pipe_handshake_source #(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 4,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         in_data,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_data,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic [COUNT_WIDTH-1:0]   transfer_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] FULL = LW'(DEPTH);

  // Every accepted word is written here, including the one currently shown
  // on out_data; the head always lives at rd_ptr. The output register is a
  // copy of the head so downstream sees a clean flop.
  logic [WIDTH-1:0] mem [DEPTH];

  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    rd_next;
  logic [LW-1:0]    level_nxt;
  logic             run;
  logic             push;
  logic             pop;

  // run holds in_ready low during reset and until the first edge after release
  assign in_ready  = run && (level != FULL);
  assign out_valid = (level != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign rd_next   = rd_ptr + PW'(1);

  always_comb begin
    level_nxt = level;
    if (push && !pop) begin
      level_nxt = level + LW'(1);
    end else if (pop && !push) begin
      level_nxt = level - LW'(1);
    end
  end

  // Storage array: data only, never reset
  always_ff @(posedge clock) begin
    if (push && !flush) begin
      mem[wr_ptr] <= in_data;
    end
  end

  // Control, counter and output register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      run            <= 1'b0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      level          <= '0;
      out_data       <= '0;
      transfer_count <= '0;
    end else begin
      run <= 1'b1;
      if (flush) begin
        // out_data is left alone; out_valid falls with level
        wr_ptr <= '0;
        rd_ptr <= '0;
        level  <= '0;
      end else begin
        level <= level_nxt;
        if (push) begin
          wr_ptr <= wr_ptr + PW'(1);
        end
        if (pop) begin
          rd_ptr         <= rd_next;
          transfer_count <= transfer_count + COUNT_WIDTH'(1);
        end
        // Load the output register only when a new word becomes the head:
        // empty->push takes in_data directly; a pop with more stored words
        // takes the next entry; a pop of the last word with a concurrent
        // push passes in_data straight through.
        if (level == '0 && push) begin
          out_data <= in_data;
        end else if (pop && level > LW'(1)) begin
          out_data <= mem[rd_next];
        end else if (pop && level == LW'(1) && push) begin
          out_data <= in_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_pipe_handshake_source.sv
module tb_pipe_handshake_source;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int CW    = 16;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready = 1'b0;
  logic [2:0]       level;
  logic [CW-1:0]    transfer_count;

  pipe_handshake_source #(.WIDTH(WIDTH), .DEPTH(DEPTH), .COUNT_WIDTH(CW)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .level(level), .transfer_count(transfer_count)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_count = 0;

  logic [WIDTH-1:0] sb_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // Monitor on the falling edge: sees exactly what the next rising edge acts on
  logic             hold_prev = 1'b0;
  logic [WIDTH-1:0] hold_data = '0;

  always @(negedge clock) begin
    if (!reset) begin
      sb_q.delete();
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        check("hold_valid", {31'd0, out_valid}, 32'd1);
        check("hold_data", {24'd0, out_data}, {24'd0, hold_data});
      end
      if (flush) begin
        sb_q.delete();
        hold_prev = 1'b0;
      end else begin
        if (out_valid && out_ready) begin
          check("sb_nonempty", {31'd0, sb_q.size() != 0}, 32'd1);
          if (sb_q.size() != 0) begin
            logic [WIDTH-1:0] e;
            e = sb_q.pop_front();
            check("sb_data", {24'd0, out_data}, {24'd0, e});
          end
          exp_count++;
        end
        if (in_valid && in_ready) sb_q.push_back(in_data);
        hold_prev = out_valid && !out_ready;
        hold_data = out_data;
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    int n;

    // Reset state
    #3;
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_data", {24'd0, out_data}, 32'd0);
    check("rst_level", {29'd0, level}, 32'd0);
    check("rst_count", {16'd0, transfer_count}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    step();
    reset = 1'b1;
    check("rel_in_ready_pre", {31'd0, in_ready}, 32'd0);
    step();
    check("rel_in_ready_post", {31'd0, in_ready}, 32'd1);

    // 1: single word, 1-cycle latency
    in_valid = 1'b1; in_data = 8'h11; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check("t1_valid", {31'd0, out_valid}, 32'd1);
    check("t1_data", {24'd0, out_data}, 32'h11);
    step();
    check("t1_level", {29'd0, level}, 32'd0);
    check("t1_count", {16'd0, transfer_count}, 32'd1);

    // 2: fill with downstream stalled, then drain
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_data = 8'hA0 + 8'(i);
      step();
    end
    in_valid = 1'b0;
    check("t2_level", {29'd0, level}, 32'd4);
    check("t2_in_ready", {31'd0, in_ready}, 32'd0);
    check("t2_head", {24'd0, out_data}, 32'hA0);
    check("t2_sb_size", sb_q.size(), 32'd4);
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("t2_drain_data", {24'd0, out_data}, 32'hA0 + 32'(k));
      check("t2_drain_valid", {31'd0, out_valid}, 32'd1);
      step();
    end
    check("t2_empty", {29'd0, level}, 32'd0);
    check("t2_count", {16'd0, transfer_count}, 32'd5);

    // 3: streaming
    for (int i = 0; i < 100; i++) begin
      in_valid = 1'b1; in_data = 8'(i);
      step();
      check("t3_level", {29'd0, level}, 32'd1);
      check("t3_valid", {31'd0, out_valid}, 32'd1);
    end
    in_valid = 1'b0;
    step();
    check("t3_count", {16'd0, transfer_count}, 32'd105);
    check("t3_level_end", {29'd0, level}, 32'd0);

    // 4: random handshake
    for (int i = 0; i < 1000; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = 8'($urandom);
      out_ready = 1'($urandom_range(0, 1));
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    n = 0;
    while (level != 0 && n < 10) begin step(); n++; end
    check("t4_drained", {29'd0, level}, 32'd0);
    check("t4_sb_empty", sb_q.size(), 32'd0);
    check("t4_count", {16'd0, transfer_count}, 32'(exp_count[15:0]));

    // 5: flush with concurrent push and pop
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 8'hC0 + 8'(i);
      step();
    end
    check("t5_level3", {29'd0, level}, 32'd3);
    n = exp_count;
    flush = 1'b1; in_valid = 1'b1; in_data = 8'h55; out_ready = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("t5_level", {29'd0, level}, 32'd0);
    check("t5_valid", {31'd0, out_valid}, 32'd0);
    check("t5_count", {16'd0, transfer_count}, 32'(n[15:0]));
    for (int i = 0; i < 3; i++) begin
      step();
      check("t5_no_output", {31'd0, out_valid}, 32'd0);
    end

    // 6: counter wrap, then reset mid-stream
    in_valid = 1'b1; out_ready = 1'b1;
    n = 0;
    while (transfer_count != 16'hFFFF && n < 70000) begin
      in_data = 8'(n);
      step();
      n++;
    end
    check("t6_preset_reached", {16'd0, transfer_count}, 32'hFFFF);
    in_valid = 1'b0;
    step();
    check("t6_wrap", {16'd0, transfer_count}, 32'd0);
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_data = 8'hE0 + 8'(i);
      step();
    end
    in_valid = 1'b0;
    check("t6_level2", {29'd0, level}, 32'd2);
    #2;
    reset = 1'b0;
    #1;
    check("t6_rst_valid", {31'd0, out_valid}, 32'd0);
    check("t6_rst_level", {29'd0, level}, 32'd0);
    check("t6_rst_in_ready", {31'd0, in_ready}, 32'd0);
    step();
    reset = 1'b1;
    check("t6_rel_level", {29'd0, level}, 32'd0);
    step();
    check("t6_rel_in_ready", {31'd0, in_ready}, 32'd1);
    check("t6_rel_valid", {31'd0, out_valid}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pipe_handshake_source.md
Name: pipe_handshake_source

Overview:
- Transmitter (upstream) end of the pipe handshake interface: valid/ready/data with WIDTH-bit payload.
- Accepts words from a local push port into a DEPTH-word FIFO and presents them downstream in order, one per cycle.
- Enforces handshake hold rules and counts completed transfers.
- Pairs with the existing down-side consumer blocks on the same handshake interface.

Parameters:
- WIDTH, 8, payload width in bits.
- DEPTH, 4, total word storage. Power of 2, at least 2. Includes the output register.
- COUNT_WIDTH, 16, width of the transfer counter.

Ports:
- clock  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- flush  input  1  synchronous clear of all stored words.
- in_valid  input  1  local push request.
- in_data  input  WIDTH  local push payload.
- in_ready  output  1  block can accept a push this cycle.
- out_valid  output  1  handshake valid to downstream.
- out_data  output  WIDTH  handshake payload to downstream.
- out_ready  input  1  downstream accepts.
- level  output  $clog2(DEPTH)+1  words currently held, 0..DEPTH.
- transfer_count  output  COUNT_WIDTH  completed out handshakes.

Behaviour:
- Reset (reset=0, async):
  - out_valid=0, out_data=0, level=0, transfer_count=0.
  - Read and write pointers = 0.
  - in_ready=0 while reset is asserted. in_ready=1 from the first clock edge after release.
- Push: occurs when in_valid & in_ready at a rising edge.
- Pop: occurs when out_valid & out_ready at a rising edge.
- in_ready = (level != DEPTH). Derived combinationally from registered level only. Never depends on out_ready, so there is no full-state bypass.
- Latency: a push into an empty block gives out_valid=1 with that data on the next cycle (1-cycle latency). Sustained throughput is 1 word/cycle when out_ready=1.
- out_data is a register.
  - It loads the FIFO head on the edge where a new word becomes presented: either the block was empty, or a pop occurs and more words remain.
  - If the block is empty and a push occurs, in_data loads directly into the output register.
- Hold rule: once out_valid=1, out_valid and out_data stay unchanged until a pop, unless flush or reset intervenes.
- Level update:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged on simultaneous push and pop. This is legal at any level < DEPTH, including level=1 (pass-through, out_valid stays 1 with the new word).
- Ordering: strict FIFO. Pointers wrap modulo DEPTH.
- transfer_count: +1 per pop. Wraps from 2^COUNT_WIDTH−1 to 0. Not cleared by flush.
- Flush (synchronous), on the edge where flush=1:
  - level=0, pointers=0, out_valid=0.
  - A push and a pop in the same cycle are both ignored and transfer_count does not increment.
  - out_data keeps its old value.
- Reset mid-transfer: all stored words are discarded immediately. out_valid drops asynchronously.
- in_valid while in_ready=0: the word is not stored. The source must hold it (standard handshake).
- X-free: out_data never shows uninitialised memory when out_valid=1.

Test Plan:
1. Reset release, then push 0x11 at cycle 0 with out_ready=1 → out_valid=1 / out_data=0x11 at cycle 1; popped at cycle 1; level=0 and transfer_count=1 at cycle 2.
2. out_ready=0, push 0xA0..0xA5 back-to-back → 0xA0..0xA3 accepted; in_ready=0 after the 4th push; level=4; out_data stays 0xA0. Then out_ready=1 → 0xA0,0xA1,0xA2,0xA3 on consecutive cycles; transfer_count=4.
3. Streaming: in_valid=1 and out_ready=1 for 100 cycles with incrementing data → level stays at 1; 100 words out in order, no gaps after the first; transfer_count=100.
4. Random in_valid and out_ready (50% each, 1000 cycles) with a scoreboard → no loss, duplication or reordering; out_data stable whenever out_valid=1 & out_ready=0.
5. Level=3, assert flush together with push 0x55 and out_ready=1 → next cycle level=0, out_valid=0, transfer_count unchanged; 0x55 is never output.
6. Preset transfer_count=0xFFFF by forcing 65535 pops, then one more pop → 0x0000. Assert reset mid-stream with level=2 → out_valid=0 immediately; after release level=0.
